// File: rtl/hl_pkg.sv
// Shared types and default sizes for the host launcher.
package hl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_GUARD,
        S_RUN,
        S_DRAIN,
        S_ERR
    } state_t;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int TW_DEF = 16;
    localparam logic [15:0] TIMEOUT_DEF = 16'd4000;

endpackage

// File: rtl/hl_timer.sv
// Run-length counter with clear/enable.
// expired flags the last allowed RUN cycle.
import hl_pkg::*;

module hl_timer #(
    parameter int TW = TW_DEF,
    parameter logic [TW-1:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/host_launcher.sv
// Host-side initiator: preload memory, pulse req, wait for done
// with a timeout, then stream a result block back out.
import hl_pkg::*;

module host_launcher #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF,
    parameter logic [TW-1:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_cnt,
    input  logic [AW-1:0] rd_base,
    input  logic [AW:0]   rd_cnt,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          mem_own,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_rd_dat,
    output logic          req,
    input  logic          done,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          fin,
    output logic          timeout
);

    state_t        state, state_nx;
    logic [AW:0]   idx, idx_nx;
    logic [AW-1:0] lb, rb;
    logic [AW:0]   lc, rc;
    logic          timer_clr, timer_en, expired;

    hl_timer #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        ld_ready  = 1'b0;
        mem_own   = 1'b0;
        mem_addr  = '0;
        mem_dat   = '0;
        mem_wr_en = 1'b0;
        req       = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    idx_nx   = '0;
                    state_nx = (ld_cnt != '0) ? S_LOAD : S_LAUNCH;
                end
            end
            S_LOAD: begin
                mem_own   = 1'b1;
                ld_ready  = 1'b1;
                mem_addr  = lb + idx[AW-1:0];
                mem_dat   = ld_data;
                mem_wr_en = ld_valid;
                if (ld_valid) begin
                    if (idx == lc - 1'b1) begin
                        idx_nx   = '0;
                        state_nx = S_LAUNCH;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                req      = 1'b1;
                state_nx = S_GUARD;
            end
            // A done left high by the previous run is not trusted here.
            S_GUARD: begin
                timer_clr = 1'b1;
                state_nx  = S_RUN;
            end
            S_RUN: begin
                timer_en = 1'b1;
                if (done) begin
                    state_nx = S_DRAIN;
                end else if (expired) begin
                    state_nx = S_ERR;
                end
            end
            S_DRAIN: begin
                if (rc == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    mem_own   = 1'b1;
                    mem_addr  = rb + idx[AW-1:0];
                    res_data  = mem_rd_dat;
                    res_valid = 1'b1;
                    if (res_ready) begin
                        if (idx == rc - 1'b1) begin
                            idx_nx   = '0;
                            state_nx = S_IDLE;
                        end else begin
                            idx_nx = idx + 1'b1;
                        end
                    end
                end
            end
            S_ERR: begin
                mem_own  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            fin     <= 1'b0;
            timeout <= 1'b0;
            lb      <= '0;
            rb      <= '0;
            lc      <= '0;
            rc      <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            busy  <= (state_nx != S_IDLE);
            fin   <= (state != S_IDLE) && (state_nx == S_IDLE);
            if (state == S_IDLE && start) begin
                lb      <= ld_base;
                lc      <= ld_cnt;
                rb      <= rd_base;
                rc      <= rd_cnt;
                timeout <= 1'b0;
            end
            if (state_nx == S_ERR) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_host_launcher.sv
// Randomized scoreboard bench for host_launcher with a memory
// and processor model around it.
module tb_host_launcher;

    localparam int TMO = 4000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ld_base, rd_base;
    logic [8:0] ld_cnt, rd_cnt;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       mem_own;
    logic [7:0] mem_addr, mem_dat, mem_rd_dat;
    logic       mem_wr_en;
    logic       req, done;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       busy, fin, timeout;

    logic       proc_we;
    logic [7:0] proc_addr, proc_dat;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int         wq [$];
    int         rq [$];
    logic [7:0] preset [$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;

    bit         hold_pend = 0;
    logic [7:0] hold_d, hold_a;
    bit         prev_req = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    host_launcher dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ld_base    (ld_base),
        .ld_cnt     (ld_cnt),
        .rd_base    (rd_base),
        .rd_cnt     (rd_cnt),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .mem_own    (mem_own),
        .mem_addr   (mem_addr),
        .mem_dat    (mem_dat),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_dat (mem_rd_dat),
        .req        (req),
        .done       (done),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy),
        .fin        (fin),
        .timeout    (timeout)
    );

    // Data memory: host port when owned, processor port otherwise.
    assign mem_rd_dat = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_own && mem_wr_en) mem[mem_addr] <= mem_dat;
        else if (!mem_own && proc_we) mem[proc_addr] <= proc_dat;
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 0;
            prev_req = 0;
        end else begin
            if (mem_wr_en) begin
                if (wq.size() == 0) chk("unexpected_write", int'(mem_addr), -1);
                else begin
                    int e;
                    e = wq.pop_front();
                    chk("wr_addr", int'(mem_addr), e >> 8);
                    chk("wr_data", int'(mem_dat), e & 255);
                    chk("wr_own", int'(mem_own), 1);
                end
            end
            if (hold_pend) begin
                chk("hold_valid", int'(res_valid), 1);
                chk("hold_data", int'(res_data), int'(hold_d));
                chk("hold_addr", int'(mem_addr), int'(hold_a));
            end
            if (res_valid && res_ready) begin
                if (rq.size() == 0) chk("unexpected_res", int'(res_data), -1);
                else chk("res_data", int'(res_data), rq.pop_front());
            end
            hold_pend = res_valid && !res_ready;
            hold_d = res_data;
            hold_a = mem_addr;
            if (req) begin
                chk("req_pulse", int'(prev_req), 0);
                chk("req_busy", int'(busy), 1);
                chk("req_own", int'(mem_own), 0);
            end
            prev_req = req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input int lb, input int lc, input int rb,
                           input int rc, input int dly, input int gap,
                           input int rrm, input bit stale, input bit to,
                           input bit ign, input int cut);
        logic [7:0] d [$];
        int pw_n, pw_base, t_req, t_run, k, nbeat;
        logic [7:0] pw_v [$];
        bit got;
        nbeat = (cut >= 0) ? cut : lc;
        for (int i = 0; i < lc; i++) begin
            if (preset.size() != 0) d.push_back(preset.pop_front());
            else d.push_back(8'($urandom));
        end
        for (int i = 0; i < nbeat; i++) begin
            wq.push_back((((lb + i) & 255) << 8) | int'(d[i]));
            ref_mem[(lb + i) & 255] = d[i];
        end
        pw_n = (to || cut >= 0) ? 0 : $urandom_range(0, 6);
        pw_base = $urandom_range(0, 255);
        for (int i = 0; i < pw_n; i++) begin
            pw_v.push_back(8'($urandom));
            ref_mem[(pw_base + i) & 255] = pw_v[i];
        end
        if (!to && cut < 0)
            for (int i = 0; i < rc; i++) rq.push_back(int'(ref_mem[(rb + i) & 255]));

        done = stale;
        start = 1; ld_base = 8'(lb); ld_cnt = 9'(lc);
        rd_base = 8'(rb); rd_cnt = 9'(rc);
        step();
        start = 0;
        ld_base = 8'($urandom); ld_cnt = 9'($urandom); rd_base = 8'($urandom);
        rd_cnt = 9'($urandom);

        for (int i = 0; i < nbeat; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                ld_valid = 0;
                step();
            end
            ld_valid = 1;
            ld_data = d[i];
            got = 0;
            for (int w = 0; w < 20 && !got; w++) begin
                @(negedge clk);
                if (ld_ready) got = 1;
                else step();
            end
            if (!got) chk("ld_ready_wait", 0, 1);
            step();
        end
        ld_valid = 0;
        if (cut >= 0) return;

        got = 0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(negedge clk);
            if (req) got = 1;
            else step();
        end
        if (!got) chk("req_wait", 0, 1);
        t_req = cyc;
        step();
        step();
        t_run = cyc;
        if (stale) done = 0;
        proc_addr = 8'(pw_base);
        for (int i = 0; i < pw_n; i++) begin
            proc_we = 1;
            proc_addr = 8'((pw_base + i) & 255);
            proc_dat = pw_v[i];
            step();
        end
        proc_we = 0;
        if (ign) begin
            start = 1; ld_cnt = 9'd7; rd_cnt = 9'd9;
            step();
            start = 0;
        end
        if (!to) begin
            while (cyc - t_run < dly) step();
            done = 1;
        end

        got = 0;
        k = 0;
        for (int w = 0; w < TMO + 3000 && !got; w++) begin
            case (rrm)
                1: res_ready = ($urandom_range(0, 2) != 0);
                2: res_ready = !(k >= 3 && k <= 7);
                default: res_ready = 1;
            endcase
            @(negedge clk);
            if (fin) got = 1;
            else begin
                step();
                k++;
            end
        end
        if (!got) chk("fin_wait", 0, 1);
        chk("fin_timeout", int'(timeout), int'(to));
        chk("fin_busy", int'(busy), 0);
        chk("fin_res_valid", int'(res_valid), 0);
        if (to) chk("timeout_cycles", cyc - t_req, TMO + 3);
        done = 0;
        res_ready = 1;
        step();
        @(negedge clk);
        chk("fin_one_cycle", int'(fin), 0);
        chk("wq_left", wq.size(), 0);
        chk("rq_left", rq.size(), 0);
        wq.delete();
        rq.delete();
        step();
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; start = 0; ld_base = 0; ld_cnt = 0; rd_base = 0;
        rd_cnt = 0; ld_valid = 0; ld_data = 0; done = 0; res_ready = 1;
        proc_we = 0; proc_addr = 0; proc_dat = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_ld_ready", int'(ld_ready), 0);
        chk("rst_mem_own", int'(mem_own), 0);
        chk("rst_mem_wr_en", int'(mem_wr_en), 0);
        chk("rst_req", int'(req), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fin", int'(fin), 0);
        chk("rst_timeout", int'(timeout), 0);
        step();

        for (int a = 0; a < 256; a++) begin
            proc_we = 1;
            proc_addr = 8'(a);
            proc_dat = 8'($urandom);
            ref_mem[a] = proc_dat;
            step();
        end
        proc_we = 0;

        preset.push_back(8'hAA);
        preset.push_back(8'hBB);
        preset.push_back(8'hCC);
        run_cmd(8'h10, 3, 8'h20, 2, 50, 0, 0, 0, 0, 0, -1);
        run_cmd(8'hFE, 4, 8'hF0, 256, 20, 0, 1, 0, 0, 0, -1);
        run_cmd(8'h33, 256, 8'h30, 1, 12, 0, 0, 0, 0, 0, -1);
        run_cmd(8'h40, 6, 8'h3E, 12, 15, 1, 2, 0, 0, 0, -1);
        run_cmd(8'h80, 2, 8'h80, 4, 10, 0, 0, 1, 0, 0, -1);
        run_cmd(8'h00, 2, 8'h00, 3, 0, 0, 0, 0, 1, 0, -1);
        run_cmd(8'h55, 0, 8'h66, 0, 12, 0, 0, 0, 0, 1, -1);

        run_cmd(8'hA0, 5, 8'h00, 4, 0, 0, 0, 0, 0, 0, 2);
        reset = 1;
        step();
        @(negedge clk);
        chk("mid_rst_own", int'(mem_own), 0);
        chk("mid_rst_wr_en", int'(mem_wr_en), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ld_ready", int'(ld_ready), 0);
        chk("mid_rst_wq", wq.size(), 0);
        reset = 0;
        step();
        run_cmd(8'hA0, 3, 8'h9F, 6, 14, 0, 0, 0, 0, 0, -1);

        for (int r = 0; r < 6; r++) begin
            run_cmd($urandom_range(0, 255), $urandom_range(0, 40),
                    $urandom_range(0, 255), $urandom_range(0, 40),
                    $urandom_range(12, 40), $urandom_range(0, 2),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0,
                    1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/host_launcher.md
Name: host_launcher

Overview:
- Host-side initiator for the processor's req/done handshake.
- On a host command it does four things in order:
  - preloads a byte block into data memory from a valid/ready stream;
  - launches the processor with a one-cycle req;
  - waits for done, bounded by a timeout;
  - streams a result block back out of data memory over a valid/ready interface.
- Sits between the host/testbench and the processor top level. It owns the data-memory port through a mux select whenever the processor is not running.

Parameters:
- AW, 8, data-memory address width.
- DW, 8, data width.
- TW, 16, timeout counter width.
- TIMEOUT, 16'd4000, maximum RUN cycles before error.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- ld_base  in  AW  preload start address.
- ld_cnt  in  AW+1  preload byte count, 0..2^AW.
- rd_base  in  AW  readback start address.
- rd_cnt  in  AW+1  readback byte count, 0..2^AW.
- ld_valid  in  1  preload data valid.
- ld_data  in  DW  preload byte.
- ld_ready  out  1  preload accept.
- mem_own  out  1  1 = host drives data-memory address/data/wr_en.
- mem_addr  out  AW  data-memory address.
- mem_dat  out  DW  data-memory write data.
- mem_wr_en  out  1  data-memory write strobe.
- mem_rd_dat  in  DW  data-memory read data (asynchronous read).
- req  out  1  processor start pulse.
- done  in  1  processor finished (level).
- res_valid  out  1  result byte valid.
- res_data  out  DW  result byte.
- res_ready  in  1  result accept.
- busy  out  1  state != IDLE.
- fin  out  1  one-cycle pulse on return to IDLE.
- timeout  out  1  sticky error flag; cleared by next accepted start.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0: req, mem_own, mem_wr_en, ld_ready, res_valid, busy, fin, timeout.
  - idx=0, timer=0.
  - Reset mid-operation aborts immediately; no partial-write completion.
- States: IDLE, LOAD, LAUNCH, GUARD, RUN, DRAIN, ERR.
- IDLE:
  - start=1 latches ld_base, ld_cnt, rd_base, rd_cnt, clears timeout and idx.
  - Next state: LOAD if ld_cnt!=0, else LAUNCH.
  - start in any other state is ignored.
- LOAD:
  - mem_own=1, ld_ready=1.
  - mem_addr = ld_base+idx, mod 2^AW (wraps).
  - mem_dat = ld_data.
  - mem_wr_en = ld_valid (combinational).
  - Each accepted beat increments idx. The beat with idx==ld_cnt-1 moves to LAUNCH, idx cleared.
  - ld_valid=0 stalls; no write occurs.
- LAUNCH:
  - mem_own=0, req=1 for exactly this one cycle → GUARD.
- GUARD:
  - One cycle; done ignored, since a stale done may still be high from the previous run → RUN, timer=0.
- RUN:
  - mem_own=0, timer increments each cycle.
  - done=1 → DRAIN (priority over timeout on the same cycle).
  - timer==TIMEOUT-1 with done=0 → ERR.
- DRAIN:
  - If rd_cnt==0, goes straight to IDLE.
  - Otherwise: mem_own=1, mem_addr=rd_base+idx (wraps), res_data=mem_rd_dat, res_valid=1.
  - The bytes are zero-latency: res_data follows mem_addr combinationally.
  - res_valid&&res_ready increments idx. The last beat → IDLE with fin=1.
  - res_valid stays high with res_data stable until accepted (AXI-style; no retraction).
- ERR:
  - timeout=1 (sticky), mem_own=1, no readback → IDLE with fin=1 next cycle.
- Counts are AW+1 bits so a full 2^AW block is legal. idx is AW+1 bits; the address uses its low AW bits.
- busy is registered from state. fin is a registered one-cycle pulse.

Decomposition:
- Package hl_pkg holds:
  - the state_t enum (7 states, 3-bit);
  - default widths AW_DEF, DW_DEF, TW_DEF and the TIMEOUT_DEF constant.
- One sub-module, hl_timer:
  - TW-bit counter with clear/enable and an expired output at TIMEOUT-1.
  - Instantiated once in RUN control.

Test Plan:
- Basic run: start with ld_base=0x10, ld_cnt=3, data 0xAA,0xBB,0xCC, rd_base=0x20, rd_cnt=2.
  - Memory writes land at 0x10..0x12.
  - req is high for 1 cycle.
  - done asserted 50 cycles later → bytes at 0x20,0x21 streamed out, then fin pulse, timeout=0.
- Wrap and full-size transfers:
  - ld_base=0xFE, ld_cnt=4 → writes to 0xFE,0xFF,0x00,0x01.
  - rd_cnt=256 → 256 beats, addresses wrap once.
- Backpressure on both streams:
  - ld_valid toggles every other cycle → only valid beats are written.
  - res_ready low for 5 cycles mid-drain → res_valid held, res_data and mem_addr stable, no beat lost.
- Stale done and timeout:
  - done held high through LAUNCH/GUARD then dropped → not taken as completion.
  - done never reasserts → after TIMEOUT cycles, timeout=1, fin pulses, no res_valid.
  - Next start clears timeout.
- Zero counts and ignored start:
  - ld_cnt=0, rd_cnt=0 → IDLE→LAUNCH→GUARD→RUN→DRAIN→IDLE, fin pulse.
  - start pulsed during RUN → ignored, latched parameters unchanged.
- Reset mid-operation:
  - reset asserted during LOAD (idx=2) → next cycle IDLE, mem_own=0, mem_wr_en=0, busy=0.
  - A following start behaves as after power-up.
